syswb_tick_scheduler: RTL

Tick-driven software-alarm scheduler. It sits on the Avalon-MM bus beside the system interval timer and consumes that timer's periodic timeout pulse as its tick. It runs up to four independent 16-bit countdown slots through one shared decrementer, sequenced by a scan FSM. It raises a single maskable IRQ when any slot expires, offloading multi-rate OS timing from the CPU.

---
 rtl/syswb_tick_scheduler.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/syswb_tick_scheduler.sv
// Tick-driven alarm scheduler: up to four 16-bit countdown slots serviced by one
// shared decrementer during a scan. Optional TICKS counter: SYSWB_TICKSCHED_TICKCNT_EN.
module syswb_tick_scheduler #(
  parameter int NUM_SLOTS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int         SLOT_MASK_I = (1 << NUM_SLOTS) - 1;
  localparam logic [3:0] SLOT_MASK   = SLOT_MASK_I[3:0];
  localparam logic [1:0] LAST_IDX    = 2'(NUM_SLOTS - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;

  state_e      state_q;
  logic [1:0]  idx_q;
  logic        pend_q;
  logic        tick_d_q;
  logic        tick_evt;
  logic        busy;

  logic [3:0]  enable_q, enable_d;
  logic [3:0]  periodic_q, periodic_d;
  logic [3:0]  expired_q, expired_d;
  logic [3:0]  mask_q;
  logic        gie_q;
  logic        overrun_q, overrun_d, overrun_set;
  logic [1:0]  sel_q;

  logic [15:0] count_w  [4];
  logic [15:0] reload_w [4];
  logic [3:0]  expire_set;
  logic [3:0]  oneshot_clr;
  logic [15:0] ticks_w;

  logic [15:0] readdata_q, readdata_d;
  logic        irq_q;

  logic        wr_en, wr_status, wr_control, wr_mask, wr_sel, wr_reload;

  assign wr_en      = chipselect & ~write_n;
  assign wr_status  = wr_en && (address == 3'd0);
  assign wr_control = wr_en && (address == 3'd1);
  assign wr_mask    = wr_en && (address == 3'd2);
  assign wr_sel     = wr_en && (address == 3'd3);
  assign wr_reload  = wr_en && (address == 3'd4);

  assign tick_evt    = tick_in & ~tick_d_q;
  assign busy        = (state_q == SCAN);
  // A tick that finds one already pending cannot be queued and is dropped.
  assign overrun_set = tick_evt && (state_q == SCAN) && pend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_d_q <= 1'b0;
    end else begin
      tick_d_q <= tick_in;
    end
  end

  // Scan sequencer: one slot per cycle, rescans immediately if a tick queued up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_evt) begin
            state_q <= SCAN;
            idx_q   <= 2'd0;
          end
        end
        SCAN: begin
          if (idx_q == LAST_IDX) begin
            idx_q  <= 2'd0;
            pend_q <= 1'b0;
            if (pend_q || tick_evt) begin
              state_q <= SCAN;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            idx_q <= idx_q + 2'd1;
            if (tick_evt) begin
              pend_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= 2'd0;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    if (gi < NUM_SLOTS) begin : g_impl
      logic [15:0] count_q, count_d;
      logic [15:0] reload_q;
      logic        reload_wr;
      logic        active;

      assign reload_wr = wr_reload && (sel_q == 2'(gi));
      // A CPU reload in the scan cycle of this slot overrides the decrement/expiry.
      assign active    = busy && (idx_q == 2'(gi)) && enable_q[gi] && !reload_wr;

      assign expire_set[gi]  = active && (count_q == 16'd1);
      assign oneshot_clr[gi] = expire_set[gi] && !periodic_q[gi];

      always_comb begin
        count_d = count_q;
        if (reload_wr) begin
          count_d = writedata;
        end else if (expire_set[gi]) begin
          count_d = periodic_q[gi] ? reload_q : 16'd0;
        end else if (active && (count_q > 16'd1)) begin
          count_d = count_q - 16'd1;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count_q  <= 16'd0;
          reload_q <= 16'd0;
        end else begin
          count_q <= count_d;
          if (reload_wr) begin
            reload_q <= writedata;
          end
        end
      end

      assign count_w[gi]  = count_q;
      assign reload_w[gi] = reload_q;
    end else begin : g_none
      assign expire_set[gi]  = 1'b0;
      assign oneshot_clr[gi] = 1'b0;
      assign count_w[gi]     = 16'd0;
      assign reload_w[gi]    = 16'd0;
    end
  end

  // Hardware sets win over CPU clears; one-shot auto-clear wins over a CONTROL write.
  always_comb begin
    enable_d   = enable_q;
    periodic_d = periodic_q;
    if (wr_control) begin
      enable_d   = writedata[3:0] & SLOT_MASK;
      periodic_d = writedata[7:4] & SLOT_MASK;
    end
    enable_d = enable_d & ~oneshot_clr;

    expired_d = expired_q;
    if (wr_status) begin
      expired_d = expired_d & ~writedata[3:0];
    end
    expired_d = (expired_d | expire_set) & SLOT_MASK;

    overrun_d = overrun_q;
    if (wr_status && writedata[4]) begin
      overrun_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 4'd0;
      periodic_q <= 4'd0;
      expired_q  <= 4'd0;
      overrun_q  <= 1'b0;
      gie_q      <= 1'b0;
      mask_q     <= 4'd0;
      sel_q      <= 2'd0;
    end else begin
      enable_q   <= enable_d;
      periodic_q <= periodic_d;
      expired_q  <= expired_d;
      overrun_q  <= overrun_d;
      if (wr_control) begin
        gie_q <= writedata[8];
      end
      if (wr_mask) begin
        mask_q <= writedata[3:0] & SLOT_MASK;
      end
      if (wr_sel && (writedata < 16'(NUM_SLOTS))) begin
        sel_q <= writedata[1:0];
      end
    end
  end

`ifdef SYSWB_TICKSCHED_TICKCNT_EN
  logic [15:0] ticks_q;
  logic        wr_ticks;

  assign wr_ticks = wr_en && (address == 3'd6);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ticks_q <= 16'd0;
    end else if (wr_ticks) begin
      ticks_q <= 16'd0;
    end else if (tick_evt) begin
      ticks_q <= ticks_q + 16'd1;
    end
  end

  assign ticks_w = ticks_q;
`else
  assign ticks_w = 16'd0;
`endif

  always_comb begin
    readdata_d = 16'd0;
    case (address)
      3'd0:    readdata_d = {10'd0, busy, overrun_q, expired_q};
      3'd1:    readdata_d = {7'd0, gie_q, periodic_q, enable_q};
      3'd2:    readdata_d = {12'd0, mask_q};
      3'd3:    readdata_d = {14'd0, sel_q};
      3'd4:    readdata_d = reload_w[sel_q];
      3'd5:    readdata_d = count_w[sel_q];
      3'd6:    readdata_d = ticks_w;
      default: readdata_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= 16'd0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_q      <= gie_q & |(expired_q & mask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
